// File: rtl/udp_tx_pkg.sv
// Shared types and helpers for the UDP transmit serializer: header size,
// controller states and the ones'-complement adder used by the checksum.
package udp_tx_pkg;

  localparam int UDP_HDR_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CSUM,
    SEND,
    GAP
  } state_e;

  // 16-bit ones'-complement addition with end-around carry.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// Running ones'-complement sum for one datagram; presents the final UDP
// checksum with zero remapped to 16'hFFFF.
module udp_csum_acc
  import udp_tx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_init,
  input  logic [15:0] i_init_val,
  input  logic        i_add,
  input  logic [15:0] i_add_val,
  input  logic        i_clear,
  output logic [15:0] o_csum
);

  logic [15:0] acc;
  logic [15:0] raw_csum;

  // NOTE: sequential state uses <= so every register samples pre-edge values,
  // independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
    end else if (i_clear) begin
      acc <= '0;
    end else if (i_init) begin
      acc <= i_init_val;
    end else if (i_add) begin
      acc <= ones_add(acc, i_add_val);
    end
  end

  // A computed checksum of zero is sent as all-ones; zero means "no checksum".
  assign raw_csum = ~acc;
  assign o_csum   = (raw_csum == 16'h0000) ? 16'hFFFF : raw_csum;

endmodule

// File: rtl/udp_tx_serializer.sv
// Buffers a UDP payload, computes its checksum and shifts the datagram out
// LSB-first: checksum, length, dst_port, src_port, then payload words.
module udp_tx_serializer
  import udp_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_PAYLOAD = 16,
  parameter int IFG_CYCLES  = 2,
  parameter int PLEN_W      = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_src_port,
  input  logic [DATA_WIDTH-1:0] i_dst_port,
  input  logic [PLEN_W-1:0]     i_pay_len,
  input  logic [DATA_WIDTH-1:0] i_pay_data,
  input  logic                  i_pay_valid,
  output logic                  o_pay_ready,
  output logic                  o_busy,
  output logic                  o_udp_data,
  output logic                  o_udp_valid,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_len_err
);

  localparam int IDX_W  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int WIDX_W = $clog2(MAX_PAYLOAD + UDP_HDR_WORDS);
  localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  state_e state, state_nxt;

  logic [DATA_WIDTH-1:0] src_q, dst_q, len_q;
  logic [PLEN_W-1:0]     plen_q;
  logic [PLEN_W-1:0]     widx;
  logic [DATA_WIDTH-1:0] buffer [MAX_PAYLOAD];
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic [WIDX_W-1:0]     word_idx, nxt_idx, last_word;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  len_err_q;

  logic                  start_ok, start_bad, pay_fire, acc_clear;
  logic                  word_done, frame_done;
  logic [DATA_WIDTH-1:0] len_in, hdr_sum, csum, next_word;

  assign len_in  = 16'(i_pay_len) + 16'(UDP_HDR_WORDS);
  assign hdr_sum = ones_add(ones_add(i_src_port, i_dst_port), len_in);

  udp_csum_acc u_csum (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_init     (start_ok),
    .i_init_val (hdr_sum),
    .i_add      (pay_fire),
    .i_add_val  (i_pay_data),
    .i_clear    (acc_clear),
    .o_csum     (csum)
  );

  // Word index counts checksum(0), length(1), dst(2), src(3), payload(4..).
  assign last_word  = WIDX_W'(plen_q) + WIDX_W'(UDP_HDR_WORDS - 1);
  assign word_done  = (bit_cnt == 4'hF);
  assign frame_done = word_done && (word_idx == last_word);
  assign nxt_idx    = word_idx + WIDX_W'(1);

  always_comb begin
    next_word = buffer[IDX_W'(nxt_idx - WIDX_W'(UDP_HDR_WORDS))];
    if (nxt_idx == WIDX_W'(1)) begin
      next_word = len_q;
    end else if (nxt_idx == WIDX_W'(2)) begin
      next_word = dst_q;
    end else if (nxt_idx == WIDX_W'(3)) begin
      next_word = src_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    o_pay_ready = 1'b0;
    o_busy      = 1'b1;
    o_udp_valid = 1'b0;
    o_sof       = 1'b0;
    o_eof       = 1'b0;
    start_ok    = 1'b0;
    start_bad   = 1'b0;
    pay_fire    = 1'b0;
    acc_clear   = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (i_pay_len <= PLEN_W'(MAX_PAYLOAD)) begin
            start_ok  = 1'b1;
            state_nxt = (i_pay_len == '0) ? CSUM : LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      LOAD: begin
        o_pay_ready = 1'b1;
        pay_fire    = i_pay_valid;
        if (pay_fire && (widx + PLEN_W'(1) == plen_q)) begin
          state_nxt = CSUM;
        end
      end
      CSUM: begin
        state_nxt = SEND;
      end
      SEND: begin
        o_udp_valid = 1'b1;
        o_sof       = (word_idx == '0) && (bit_cnt == 4'h0);
        o_eof       = frame_done;
        if (frame_done) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        acc_clear = 1'b1;
        if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign o_udp_data = o_udp_valid & shreg[0];
  assign o_len_err  = len_err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      plen_q    <= '0;
      widx      <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_idx  <= '0;
      gap_cnt   <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= start_bad;
      case (state)
        IDLE: begin
          if (start_ok) begin
            src_q  <= i_src_port;
            dst_q  <= i_dst_port;
            len_q  <= len_in;
            plen_q <= i_pay_len;
            widx   <= '0;
          end
        end
        LOAD: begin
          if (pay_fire) begin
            widx <= widx + PLEN_W'(1);
          end
        end
        CSUM: begin
          shreg    <= csum;
          bit_cnt  <= '0;
          word_idx <= '0;
        end
        SEND: begin
          bit_cnt <= bit_cnt + 4'd1;
          gap_cnt <= '0;
          if (word_done) begin
            shreg    <= next_word;
            word_idx <= nxt_idx;
          end else begin
            shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the payload buffer has no reset; LOAD always writes a slot before
  // SEND reads it, so clearing it would only cost flops.
  always_ff @(posedge i_clk) begin
    if (pay_fire) begin
      buffer[widx[IDX_W-1:0]] <= i_pay_data;
    end
  end

endmodule

// File: tb/tb_udp_tx_serializer.sv
// Directed bench for udp_tx_serializer: captures each serial datagram and
// compares it with hand-computed header, checksum and framing values.
module tb_udp_tx_serializer;

  localparam int MAX_PAYLOAD = 16;
  localparam int PLEN_W      = 5;
  localparam int MAX_BITS    = 64 + 16 * MAX_PAYLOAD;
  localparam int BUDGET      = 2000;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [15:0]       i_src_port = '0;
  logic [15:0]       i_dst_port = '0;
  logic [PLEN_W-1:0] i_pay_len = '0;
  logic [15:0]       i_pay_data = '0;
  logic              i_pay_valid = 1'b0;
  logic              o_pay_ready, o_busy, o_udp_data, o_udp_valid;
  logic              o_sof, o_eof, o_len_err;

  udp_tx_serializer dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_src_port  (i_src_port),
    .i_dst_port  (i_dst_port),
    .i_pay_len   (i_pay_len),
    .i_pay_data  (i_pay_data),
    .i_pay_valid (i_pay_valid),
    .o_pay_ready (o_pay_ready),
    .o_busy      (o_busy),
    .o_udp_data  (o_udp_data),
    .o_udp_valid (o_udp_valid),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_len_err   (o_len_err)
  );

  always #5 i_clk = ~i_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        cap_bits [MAX_BITS];
  logic [15:0] pay_mem [MAX_PAYLOAD];
  logic [15:0] exp_w [MAX_PAYLOAD + 4];
  int          cap_n, sof_n, eof_n, sof_pos, eof_pos, gap_n, first_cyc;
  bit          aborted;
  logic [2:0]  abort_outs;

  function automatic logic [15:0] word_at(input int w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = cap_bits[16 * w + i];
    return r;
  endfunction

  // Reference checksum: wide sum folded afterwards, independent of the DUT adder.
  function automatic logic [15:0] model_csum(input logic [15:0] src, input logic [15:0] dst,
                                             input int plen);
    logic [31:0] s;
    logic [15:0] r;
    s = 32'(src) + 32'(dst) + 32'(4 + plen);
    for (int i = 0; i < plen; i++) s = s + 32'(pay_mem[i]);
    while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
    r = ~s[15:0];
    return (r == 16'h0) ? 16'hFFFF : r;
  endfunction

  // Starts one datagram at posedge+1, feeds payload, and records the serial
  // stream until the DUT returns to idle. Optionally pulses a stray start at
  // a given bit, or asserts reset when a given bit is on the line.
  task automatic run_frame(input logic [15:0] src, input logic [15:0] dst, input int plen,
                           input bit stall, input int pulse_bit, input int abort_bit);
    int k, cyc, t;
    bit hs, done, phase;
    cap_n = 0; sof_n = 0; eof_n = 0; sof_pos = -1; eof_pos = -1;
    gap_n = 0; first_cyc = -1; aborted = 0; abort_outs = 'x;
    for (int i = 0; i < MAX_BITS; i++) cap_bits[i] = 1'bx;
    k = 0; cyc = 0; t = 0; done = 0; phase = 0;
    i_src_port = src; i_dst_port = dst; i_pay_len = PLEN_W'(plen); i_start = 1'b1;
    while (!done && t < BUDGET) begin
      hs = i_pay_valid && o_pay_ready;
      @(posedge i_clk); #1;
      cyc++; t++;
      if (hs) k++;
      i_start = 1'b0;
      if (cyc == 1) begin
        i_src_port = ~src; i_dst_port = ~dst; i_pay_len = '0;
      end
      if (abort_bit >= 0 && o_udp_valid && cap_n == abort_bit) begin
        i_rst_n = 1'b0;
        #1;
        aborted = 1;
        abort_outs = {o_udp_valid, o_eof, o_busy};
        i_pay_valid = 1'b0;
        done = 1;
      end else begin
        if (o_udp_valid) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (cap_n < MAX_BITS) cap_bits[cap_n] = o_udp_data;
          if (o_sof) begin sof_n++; sof_pos = cap_n; end
          if (o_eof) begin eof_n++; eof_pos = cap_n; end
          if (pulse_bit >= 0 && cap_n == pulse_bit) begin
            i_start = 1'b1; i_pay_len = '0; i_src_port = 16'h5555;
          end
          cap_n++;
        end else if (first_cyc >= 0) begin
          if (!o_busy) done = 1;
          else gap_n++;
        end
        if (o_pay_ready && k < plen) begin
          phase = ~phase;
          i_pay_valid = stall ? phase : 1'b1;
          i_pay_data = pay_mem[k];
        end else begin
          i_pay_valid = 1'b0;
          i_pay_data = 16'hDEAD;
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL frame_timeout: no idle after %0d cycles (bits=%0d), want idle", t, cap_n);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({o_busy, o_udp_valid, o_sof, o_eof, o_pay_ready, o_len_err, o_udp_data} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {o_busy, o_udp_valid, o_sof, o_eof, o_pay_ready, o_len_err, o_udp_data});
    end
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_cmp++;
    if ({o_busy, o_udp_valid, o_pay_ready, o_len_err} !== 4'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want 0000", {o_busy, o_udp_valid, o_pay_ready, o_len_err});
    end
  endtask

  task automatic test_header_only();
    run_frame(16'h0007, 16'h0002, 0, 0, -1, -1);
    exp_w[0] = 16'hFFF2; exp_w[1] = 16'h0004; exp_w[2] = 16'h0002; exp_w[3] = 16'h0007;
    n_cmp++;
    if (cap_n !== 64) begin n_err++; $display("FAIL hdr_bits: got %0d want 64", cap_n); end
    for (int w = 0; w < 4; w++) begin
      n_cmp++;
      if (word_at(w) !== exp_w[w]) begin
        n_err++; $display("FAIL hdr_word%0d: got %h want %h", w, word_at(w), exp_w[w]);
      end
    end
    n_cmp++;
    if (sof_n !== 1 || sof_pos !== 0) begin
      n_err++; $display("FAIL hdr_sof: got count %0d at %0d want 1 at 0", sof_n, sof_pos);
    end
    n_cmp++;
    if (eof_n !== 1 || eof_pos !== 63) begin
      n_err++; $display("FAIL hdr_eof: got count %0d at %0d want 1 at 63", eof_n, eof_pos);
    end
    n_cmp++;
    if (gap_n !== 2) begin n_err++; $display("FAIL hdr_gap: got %0d want 2", gap_n); end
    n_cmp++;
    if (first_cyc !== 2) begin n_err++; $display("FAIL hdr_latency: got %0d want 2", first_cyc); end
  endtask

  task automatic check_payload_frame(input string tag);
    exp_w[0] = 16'h41EF; exp_w[1] = 16'h0006; exp_w[2] = 16'h0002; exp_w[3] = 16'h0007;
    exp_w[4] = 16'h1234; exp_w[5] = 16'hABCD;
    n_cmp++;
    if (cap_n !== 96) begin n_err++; $display("FAIL %s_bits: got %0d want 96", tag, cap_n); end
    for (int w = 0; w < 6; w++) begin
      n_cmp++;
      if (word_at(w) !== exp_w[w]) begin
        n_err++; $display("FAIL %s_word%0d: got %h want %h", tag, w, word_at(w), exp_w[w]);
      end
    end
    n_cmp++;
    if (sof_n !== 1 || eof_n !== 1 || eof_pos !== 95 || gap_n !== 2) begin
      n_err++;
      $display("FAIL %s_framing: got sof %0d eof %0d@%0d gap %0d want 1 1@95 2",
               tag, sof_n, eof_n, eof_pos, gap_n);
    end
  endtask

  task automatic test_payload();
    pay_mem[0] = 16'h1234; pay_mem[1] = 16'hABCD;
    run_frame(16'h0007, 16'h0002, 2, 0, -1, -1);
    check_payload_frame("payload");
  endtask

  task automatic test_stall();
    pay_mem[0] = 16'h1234; pay_mem[1] = 16'hABCD;
    run_frame(16'h0007, 16'h0002, 2, 1, -1, -1);
    check_payload_frame("stall");
  endtask

  task automatic test_back_to_back();
    run_frame(16'hFFFF, 16'h0001, 0, 0, -1, -1);
    n_cmp++;
    if (word_at(0) !== 16'hFFFA || cap_n !== 64) begin
      n_err++; $display("FAIL carry_fold: got csum %h bits %0d want fffa 64", word_at(0), cap_n);
    end
    run_frame(16'hFFF0, 16'h000B, 0, 0, -1, -1);
    n_cmp++;
    if (word_at(0) !== 16'hFFFF || word_at(3) !== 16'hFFF0) begin
      n_err++; $display("FAIL zero_csum: got csum %h src %h want ffff fff0", word_at(0), word_at(3));
    end
    n_cmp++;
    if (first_cyc !== 2) begin n_err++; $display("FAIL b2b_latency: got %0d want 2", first_cyc); end
  endtask

  task automatic test_len_err();
    int pulses;
    bit busy_seen;
    pulses = 0; busy_seen = 0;
    i_pay_len = PLEN_W'(MAX_PAYLOAD + 1); i_start = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (o_len_err) pulses++;
      if (o_busy) busy_seen = 1;
    end
    n_cmp++;
    if (pulses !== 1) begin n_err++; $display("FAIL len_err_pulse: got %0d cycles want 1", pulses); end
    n_cmp++;
    if (busy_seen !== 1'b0) begin n_err++; $display("FAIL len_err_busy: got busy=1 want 0"); end
  endtask

  task automatic test_start_ignored();
    bit busy_seen;
    busy_seen = 0;
    run_frame(16'h0007, 16'h0002, 0, 0, 20, -1);
    n_cmp++;
    if (word_at(0) !== 16'hFFF2 || word_at(3) !== 16'h0007 || eof_pos !== 63) begin
      n_err++;
      $display("FAIL ignored_start_frame: got csum %h src %h eof@%0d want fff2 0007 63",
               word_at(0), word_at(3), eof_pos);
    end
    for (int t = 0; t < 8; t++) begin
      @(posedge i_clk); #1;
      if (o_busy) busy_seen = 1;
    end
    n_cmp++;
    if (busy_seen !== 1'b0) begin n_err++; $display("FAIL ignored_start_idle: got busy=1 want 0"); end
  endtask

  task automatic test_max_payload();
    logic [15:0] exp_csum;
    for (int i = 0; i < MAX_PAYLOAD; i++) pay_mem[i] = 16'hFFF0 - 16'(i * 3);
    exp_csum = model_csum(16'h8001, 16'h9002, MAX_PAYLOAD);
    run_frame(16'h8001, 16'h9002, MAX_PAYLOAD, 0, -1, -1);
    n_cmp++;
    if (cap_n !== MAX_BITS) begin n_err++; $display("FAIL max_bits: got %0d want %0d", cap_n, MAX_BITS); end
    n_cmp++;
    if (word_at(0) !== exp_csum || word_at(1) !== 16'h0014) begin
      n_err++; $display("FAIL max_hdr: got csum %h len %h want %h 0014", word_at(0), word_at(1), exp_csum);
    end
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      n_cmp++;
      if (word_at(4 + i) !== pay_mem[i]) begin
        n_err++; $display("FAIL max_pay%0d: got %h want %h", i, word_at(4 + i), pay_mem[i]);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    pay_mem[0] = 16'h1234; pay_mem[1] = 16'hABCD;
    run_frame(16'h0007, 16'h0002, 2, 0, -1, 30);
    n_cmp++;
    if (aborted !== 1'b1 || abort_outs !== 3'b000 || eof_n !== 0) begin
      n_err++;
      $display("FAIL reset_abort: got aborted %0b valid/eof/busy %b eofs %0d want 1 000 0",
               aborted, abort_outs, eof_n);
    end
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    run_frame(16'h0011, 16'h0022, 0, 0, -1, -1);
    n_cmp++;
    if (cap_n !== 64 || sof_pos !== 0 || word_at(0) !== 16'hFFC8 || word_at(3) !== 16'h0011) begin
      n_err++;
      $display("FAIL after_reset_frame: got bits %0d sof@%0d csum %h src %h want 64 0 ffc8 0011",
               cap_n, sof_pos, word_at(0), word_at(3));
    end
  endtask

  initial begin
    test_reset();
    test_header_only();
    test_payload();
    test_stall();
    test_back_to_back();
    test_len_err();
    test_start_ignored();
    test_max_payload();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
